// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, drives the ROM word address,
// captures the 1-cycle-latency ROM read data and buffers {instruction, pc}
// in a small skid FIFO presented to decode over a valid/ready handshake.
module inst_fetch_unit #(
    parameter int unsigned       ADDR_W     = 4,
    parameter int unsigned       DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] inst_in,
    output logic [DATA_W-1:0] inst_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    // Fetch state
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              inflight_q, inflight_d;

    // Skid FIFO state
    logic [DATA_W-1:0] data_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] pcs_q  [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              push;
    logic              pop;
    logic              issue;
    logic [CNT_W:0]    credit_used;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Head presentation; a redirect hides the head so no transfer can happen.
    always_comb begin
        mem_addr   = redirect_valid ? redirect_pc : fetch_pc_q;
        inst_valid = (count_q != '0) && !redirect_valid;
        inst_out   = (count_q != '0) ? data_q[rd_ptr_q] : '0;
        pc_out     = (count_q != '0) ? pcs_q[rd_ptr_q] : '0;
    end

    // Handshake, credit and issue decisions
    always_comb begin
        pop         = inst_valid & inst_ready;
        // Responses already in flight when a redirect or reset hits are dropped.
        push        = inflight_q & !redirect_valid & !RESET;
        // Entries held plus the one response still owed, minus the one leaving.
        credit_used = {1'b0, count_q} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
        // A redirect flushes the FIFO this edge, so credit is full for its request.
        issue       = !RESET &&
                      (redirect_valid || (credit_used < (CNT_W + 1)'(FIFO_DEPTH)));
    end

    // Next-state for fetch PC, in-flight tracking and FIFO pointers
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = issue;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (issue) begin
            req_pc_d   = mem_addr;
            fetch_pc_d = mem_addr + 1'b1;
        end

        if (redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; contents are only visible while count is non-zero
    always_ff @(posedge CLK) begin
        if (push) begin
            data_q[wr_ptr_q] <= inst_in;
            pcs_q[wr_ptr_q]  <= req_pc_q;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a 1-cycle synchronous ROM model
// (ROM[i] = 32'h1000 + i) and a queue of expected pcs checked on each transfer.
module tb_inst_fetch_unit;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] inst_in;
    logic [DATA_W-1:0] inst_out;
    logic [ADDR_W-1:0] pc_out;
    logic              inst_valid;
    logic              inst_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    logic [ADDR_W-1:0] exp_q[$];

    inst_fetch_unit #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .RESET_PC  ('0),
        .FIFO_DEPTH(2)
    ) dut (
        .CLK           (clk),
        .RESET         (reset),
        .mem_addr      (mem_addr),
        .inst_in       (inst_in),
        .inst_out      (inst_out),
        .pc_out        (pc_out),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    always #5 clk = ~clk;

    // ROM model: registers the word at the presented address on each posedge
    logic [DATA_W-1:0] rom_q = '0;
    always_ff @(posedge clk) rom_q <= 32'h1000 + 32'(mem_addr);
    assign inst_in = rom_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Mid-cycle sample; a transfer seen here is scored against the expected queue.
    task automatic sample();
        logic [ADDR_W-1:0] e;
        @(negedge clk);
        if (inst_valid && inst_ready) begin
            n_total++;
            assert (exp_q.size() != 0) n_pass++;
            else $error("FAIL unexpected_xfer: observed pc 0x%0h expected no transfer", pc_out);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("xfer_pc", 32'(pc_out), 32'(e));
                chk("xfer_inst", inst_out, 32'h1000 + 32'(e));
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 40) begin
            sample();
            chk(tag, 32'(inst_valid), 32'd1);
            adv();
            guard++;
        end
        chk({tag, "_drained"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        reset = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        sample(); adv();
        sample();
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst_out, 32'd0);
        chk("rst_pc", 32'(pc_out), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        adv();

        // 1: release reset, stream from pc 0
        reset = 1'b0; inst_ready = 1'b1;
        for (int i = 0; i < 16; i++) exp_q.push_back(ADDR_W'(i));
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd1);
        sample(); chk("lat_t0_valid", 32'(inst_valid), 32'd0); chk("lat_t0_addr", 32'(mem_addr), 32'd0); adv();
        sample(); chk("lat_t1_valid", 32'(inst_valid), 32'd0); adv();
        sample(); chk("lat_t2_valid", 32'(inst_valid), 32'd1); adv();
        sample(); chk("stream_valid", 32'(inst_valid), 32'd1); adv();
        sample(); chk("stream_valid", 32'(inst_valid), 32'd1); adv();

        // 2: stall with pc 3 at the head
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("stall_valid", 32'(inst_valid), 32'd1);
            chk("stall_pc", 32'(pc_out), 32'd3);
            chk("stall_inst", inst_out, 32'h1003);
            chk("stall_addr", 32'(mem_addr), 32'd5);
            adv();
        end

        // 2/3: release and stream across the wrap to pc 1
        inst_ready = 1'b1;
        drain("wrap_stream_valid");
        inst_ready = 1'b0;

        // 4: fill the FIFO, then redirect to 9 while stalled
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("fill_valid", 32'(inst_valid), 32'd1);
            chk("fill_pc", 32'(pc_out), 32'd2);
            adv();
        end
        redirect_valid = 1'b1; redirect_pc = 4'd9;
        exp_q.delete();
        exp_q.push_back(4'd9);
        exp_q.push_back(4'd10);
        sample(); chk("redir_valid", 32'(inst_valid), 32'd0); chk("redir_addr", 32'(mem_addr), 32'd9); adv();
        redirect_valid = 1'b0; inst_ready = 1'b1;
        sample(); chk("redir_t1_valid", 32'(inst_valid), 32'd0); adv();
        sample(); chk("redir_t2_valid", 32'(inst_valid), 32'd1); adv();
        sample(); chk("redir_t3_valid", 32'(inst_valid), 32'd1); adv();

        // 5: redirect to 15 while streaming with ready high
        redirect_valid = 1'b1; redirect_pc = 4'd15;
        exp_q.delete();
        exp_q.push_back(4'd15);
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd1);
        sample(); chk("redir2_valid", 32'(inst_valid), 32'd0); adv();
        redirect_valid = 1'b0;
        sample(); chk("redir2_t1_valid", 32'(inst_valid), 32'd0); adv();
        drain("redir2_stream_valid");
        inst_ready = 1'b0;

        // 6: reset with two entries buffered
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("prerst_valid", 32'(inst_valid), 32'd1);
            chk("prerst_pc", 32'(pc_out), 32'd2);
            adv();
        end
        reset = 1'b1;
        sample(); adv();
        reset = 1'b0; inst_ready = 1'b1;
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd2);
        sample();
        chk("rst2_valid", 32'(inst_valid), 32'd0);
        chk("rst2_inst", inst_out, 32'd0);
        chk("rst2_addr", 32'(mem_addr), 32'd0);
        adv();
        sample(); chk("rst2_t1_valid", 32'(inst_valid), 32'd0); adv();
        drain("rst2_stream_valid");
        inst_ready = 1'b0;
        sample(); adv();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
